score_ssd_driver: RTL
=====================

# score_ssd_driver

Converts the 16-bit zombies-killed score from the game logic into four BCD digits with a sequential shift-add-3 converter, then time-multiplexes them onto the Nexys4 seven-segment display. It sits directly downstream of `vga_bitchange`, taking its `zombies_killed` output. It drives the lower four anodes and the shared cathodes in `vga_top`.

## Interface
Parameters:
- `REFRESH_BITS`, 18 — width of the free-running scan counter.
  - The top two bits select the digit.
  - At 100 MHz this gives about 381 Hz per full refresh.
  - Legal range 3..24.

Ports:
- `clk`  in  1  — system clock (`ClkPort`, 100 MHz).
- `reset_n`  in  1  — synchronous, active-low reset.
- `value`  in  16  — unsigned binary score.
- `anode`  out  4  — digit enables, active-low; bit 0 is the rightmost digit (An0).
- `ssd_out`  out  7  — segment drives, active-low, ordered {a,b,c,d,e,f,g} at [6:0].
- `bcd_valid`  out  1  — one-cycle pulse when new digits are committed to the display registers.
- `overflow`  out  1  — level; high while the displayed value is saturated.

## Operation
- Converter FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE → LOAD when `pending` is set or `value` differs from `last_value`.
- LOAD, one cycle:
  - `last_value` ← `value`.
  - Clamp to 9999 when `value` > 9999; `ovf_next` = (`value` > 9999).
  - Clear the 16-bit BCD shift register and set the bit counter to 15.
  - Clear `pending`.
- SHIFT, exactly 16 cycles:
  - Any BCD nibble ≥ 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - Exit to DONE after the iteration with the bit counter at 0.
- DONE, one cycle:
  - Copy the four BCD nibbles into the display registers `d3..d0` atomically.
  - `overflow` ← `ovf_next`.
  - Pulse `bcd_valid` for one cycle.
  - Return to IDLE.
- Changes to `value` during LOAD, SHIFT or DONE do not disturb the active conversion. The comparison in IDLE picks them up on the cycle after DONE.
- Scan counter:
  - Increments every cycle and wraps from all-ones to 0.
  - `sel` = `scan[REFRESH_BITS-1:REFRESH_BITS-2]`; `sel` = 0 lights digit 0 (`anode` = 4'b1110), and so on up to `sel` = 3 (`anode` = 4'b0111).
- Segment patterns for digits 0–9, listed as abcdefg:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- The display shows only committed registers. A partially converted value is never shown.

## Timing
- Reset (`reset_n` = 0 at a rising edge) has the following effects:
  - `anode` = 4'b1111 and `ssd_out` = 7'b1111111.
  - `bcd_valid` = 0, `overflow` = 0.
  - `d3..d0` = 0, scan counter = 0, `last_value` = 0.
  - FSM goes to IDLE and `pending` = 1.
- Reset asserted mid-conversion aborts it. The display registers go to 0, and a fresh conversion starts after release.
- Latency from IDLE sampling a new `value` to the `bcd_valid` pulse is 18 cycles: 1 LOAD + 16 SHIFT + 1 DONE. The display registers update on the same edge as `bcd_valid`.
- First cycle after reset release: IDLE sees `pending` and goes to LOAD. `bcd_valid` pulses 18 cycles later.
- `anode` and `ssd_out` are registered and reflect `sel` and `d*` one cycle late.
  - Digit switches are glitch-free: anode and cathode change on the same edge.
- Back-to-back changes: at most one conversion is in flight. Intermediate values may be skipped, but the final stable `value` is always displayed.

## Configuration
- `SSD_LEADING_ZERO_BLANK_EN` defined:
  - A digit is blanked (its `anode` bit held 1, `ssd_out` = 7'b1111111 in its slot) when it and every more-significant digit are 0.
  - Digit 0 is never blanked.
  - Example: value 7 lights only digit 0.
- Not defined: all four digits are always lit, so value 7 shows "0007".

## Test plan
- Reset, then release with `value` = 0 → `bcd_valid` pulses 18 cycles after release. Digits are 0,0,0,0, `overflow` = 0, and `anode` cycles 1110 → 1101 → 1011 → 0111 with `REFRESH_BITS` = 4.
- `value` = 1234 → after `bcd_valid`, `d3..d0` = 1,2,3,4. `ssd_out` = 1001111 while `anode` = 0111, and 1001100 while `anode` = 1110.
- `value` = 10000, then 65535 → display 9,9,9,9 with `overflow` = 1. Then `value` = 42 → `overflow` = 0 and digits 0,0,4,2.
- `value` = 7 with the macro defined → only `anode` = 1110 ever goes low, showing 0001111. Without the macro → all four digits light, showing 0,0,0,7.
- `value` 100 → 250 during SHIFT cycle 5 → first `bcd_valid` commits 0100. The next conversion starts on the cycle after DONE, and the second `bcd_valid` commits 0250 18 cycles later.
- Hold `value` = 9999 and pulse `reset_n` low in SHIFT cycle 8 → outputs return to reset values. After release, 9999 is re-converted and committed 18 cycles later.

Source files
------------

// File: rtl/score_ssd_driver.sv
// rtl/score_ssd_driver.sv - binary score to BCD converter with multiplexed seven-segment scan
//
// Purpose:
//   Converts a 16-bit unsigned score to four BCD digits with a sequential
//   shift-add-3 converter (IDLE -> LOAD -> 16x SHIFT -> DONE). It then scans
//   the committed digits onto four active-low anodes and shared active-low
//   cathodes. Values above 9999 saturate to 9999 and raise overflow.
//
// Ports:
//   clk        in   1   system clock
//   reset_n    in   1   synchronous, active-low reset
//   value      in  16   unsigned binary score
//   anode      out  4   digit enables, active-low, bit 0 = rightmost digit
//   ssd_out    out  7   segments {a,b,c,d,e,f,g}, active-low
//   bcd_valid  out  1   one-cycle pulse when new digits are committed
//   overflow   out  1   high while the displayed value is saturated
//
// Parameters:
//   REFRESH_BITS  width of the free-running scan counter (3..24); the top
//                 two bits select the digit being driven.
//
// Configuration macro:
//   SSD_LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                              (digit 0 always lit).

module score_ssd_driver #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  ssd_out,
    output logic        bcd_valid,
    output logic        overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [15:0] MAX_DISPLAY = 16'd9999;

    // Converter state
    logic [1:0]  state_q, state_d;
    logic        pending_q, pending_d;
    logic [15:0] last_value_q, last_value_d;
    logic [15:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        ovf_next_q, ovf_next_d;

    // Committed display state; digit n lives at [4n+3:4n]
    logic [15:0] digits_q, digits_d;
    logic        overflow_q, overflow_d;
    logic        bcd_valid_q, bcd_valid_d;

    // Scan and registered display drive
    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  ssd_q, ssd_d;

    logic [15:0] bcd_adj;
    logic [1:0]  sel;
    logic [3:0]  cur_digit;
    logic        blank;

    // Any BCD nibble of 5 or more gets +3 so the following left shift
    // carries correctly into the next decade.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Converter FSM
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        last_value_d = last_value_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        bit_cnt_d    = bit_cnt_q;
        ovf_next_d   = ovf_next_q;
        digits_d     = digits_q;
        overflow_d   = overflow_q;
        bcd_valid_d  = 1'b0;
        bcd_adj      = add3(bcd_q);

        case (state_q)
            ST_IDLE: begin
                if (pending_q || (value != last_value_q)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // value is sampled here; later changes wait for the next pass
                last_value_d = value;
                if (value > MAX_DISPLAY) begin
                    bin_d      = MAX_DISPLAY;
                    ovf_next_d = 1'b1;
                end else begin
                    bin_d      = value;
                    ovf_next_d = 1'b0;
                end
                bcd_d     = 16'd0;
                bit_cnt_d = 4'd15;
                pending_d = 1'b0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                bit_cnt_d      = bit_cnt_q - 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // All four digits move together so a half-converted value is
                // never visible on the display.
                digits_d    = bcd_q;
                overflow_d  = ovf_next_q;
                bcd_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display scan
    assign sel = scan_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        scan_d    = scan_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        cur_digit = digits_q[3:0];
        case (sel)
            2'd0:    cur_digit = digits_q[3:0];
            2'd1:    cur_digit = digits_q[7:4];
            2'd2:    cur_digit = digits_q[11:8];
            default: cur_digit = digits_q[15:12];
        endcase

`ifdef SSD_LEADING_ZERO_BLANK_EN
        // A digit is dark when it and every more-significant digit are zero.
        case (sel)
            2'd3:    blank = (digits_q[15:12] == 4'd0);
            2'd2:    blank = (digits_q[15:8] == 8'd0);
            2'd1:    blank = (digits_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        if (blank) begin
            anode_d = 4'b1111;
            ssd_d   = 7'b1111111;
        end else begin
            anode_d = ~(4'b0001 << sel);
            ssd_d   = seg_decode(cur_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b1;
            last_value_q <= 16'd0;
            bin_q        <= 16'd0;
            bcd_q        <= 16'd0;
            bit_cnt_q    <= 4'd0;
            ovf_next_q   <= 1'b0;
            digits_q     <= 16'd0;
            overflow_q   <= 1'b0;
            bcd_valid_q  <= 1'b0;
            scan_q       <= '0;
            anode_q      <= 4'b1111;
            ssd_q        <= 7'b1111111;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_value_q <= last_value_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            ovf_next_q   <= ovf_next_d;
            digits_q     <= digits_d;
            overflow_q   <= overflow_d;
            bcd_valid_q  <= bcd_valid_d;
            scan_q       <= scan_d;
            anode_q      <= anode_d;
            ssd_q        <= ssd_d;
        end
    end

    assign anode     = anode_q;
    assign ssd_out   = ssd_q;
    assign bcd_valid = bcd_valid_q;
    assign overflow  = overflow_q;

endmodule
